// File: rtl/spi_resp_tx.sv
// spi_resp_tx: SPI mode-0 readback transmitter in the pck0 domain.
// Oversamples spck/ncs, shifts a 16-bit response word out on miso MSB first,
// and keeps a clear-on-read saturating event counter.
// Optional build macro SPI_RESP_PARITY_EN: puts even parity in response bit 8.
module spi_resp_tx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EVT_CNT_W   = 8
) (
    input  logic       pck0,
    input  logic       nrst,
    input  logic       spck,
    input  logic       ncs,
    input  logic [1:0] rd_sel,
    input  logic [7:0] conf_word,
    input  logic [7:0] divisor,
    input  logic [7:0] user_byte1,
    input  logic       evt,
    output logic       miso,
    output logic       miso_oe,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned WORD_W    = 16;
    localparam logic [BIT_CNT_W-1:0] FRAME_BITS = BIT_CNT_W'(WORD_W);
    localparam logic [EVT_CNT_W-1:0] EVT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        TAIL  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] spck_sync_q, ncs_sync_q;
    logic                   spck_hist_q, ncs_hist_q;
    logic                   spck_rise_q, spck_fall_q;
    logic                   ncs_rise_c, ncs_fall_c;
    logic [WORD_W-1:0]      shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [1:0]             rd_sel_q, rd_sel_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overrun_q, overrun_d;
    logic [EVT_CNT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic                   evt_sat_q, evt_sat_d;
    logic                   evt_clr_c;
    logic [7:0]             data_c;
    logic                   parity_c;
    logic [WORD_W-1:0]      word_c;

    // Synchronizers plus history flops; spck edges are registered so a miso
    // update lands SYNC_STAGES+2 cycles after the spck fall.
    always_ff @(posedge pck0) begin
        if (!nrst) begin
            spck_sync_q <= '0;
            ncs_sync_q  <= '1;
            spck_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            spck_rise_q <= 1'b0;
            spck_fall_q <= 1'b0;
        end else begin
            spck_sync_q <= {spck_sync_q[SYNC_STAGES-2:0], spck};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            spck_hist_q <= spck_sync_q[SYNC_STAGES-1];
            ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
            spck_rise_q <= spck_sync_q[SYNC_STAGES-1] & ~spck_hist_q;
            spck_fall_q <= ~spck_sync_q[SYNC_STAGES-1] & spck_hist_q;
        end
    end

    assign ncs_rise_c = ncs_sync_q[SYNC_STAGES-1] & ~ncs_hist_q;
    assign ncs_fall_c = ~ncs_sync_q[SYNC_STAGES-1] & ncs_hist_q;

    // Response word assembled from live sources; captured only in LOAD.
    always_comb begin
        data_c = conf_word;
        case (rd_sel)
            2'd0:    data_c = conf_word;
            2'd1:    data_c = divisor;
            2'd2:    data_c = user_byte1;
            default: data_c = 8'(evt_cnt_q);
        endcase
`ifdef SPI_RESP_PARITY_EN
        parity_c = ^{2'b10, rd_sel, overrun_q, evt_sat_q, data_c};
`else
        parity_c = 1'b0;
`endif
        word_c = {2'b10, rd_sel, overrun_q, evt_sat_q, 1'b0, parity_c, data_c};
    end

    // Frame state register and datapath registers.
    always_ff @(posedge pck0) begin
        if (!nrst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            rd_sel_q     <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            rd_sel_q     <= rd_sel_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next-state and output logic; an ncs rise overrides everything else.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        rd_sel_d     = rd_sel_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
                if (ncs_fall_c) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rd_sel_d  = rd_sel;
                shreg_d   = word_c;
                miso_d    = word_c[WORD_W-1];
                miso_oe_d = 1'b1;
                bit_cnt_d = '0;
                overrun_d = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (spck_rise_q && (bit_cnt_q < FRAME_BITS)) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
                if (spck_fall_q) begin
                    if (bit_cnt_q < FRAME_BITS) begin
                        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                        miso_d  = shreg_q[WORD_W-2];
                    end else begin
                        frame_done_d = 1'b1;
                        miso_d       = 1'b0;
                        state_d      = TAIL;
                    end
                end
            end
            TAIL: begin
                miso_d = 1'b0;
                if (spck_rise_q) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && ncs_rise_c) begin
            state_d      = IDLE;
            miso_d       = 1'b0;
            miso_oe_d    = 1'b0;
            frame_done_d = (state_q == SHIFT) && (bit_cnt_q == FRAME_BITS);
        end
    end

    assign evt_clr_c = frame_done_q && (rd_sel_q == 2'd3);

    // Saturating event counter, cleared after a completed counter readback.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        evt_sat_d = evt_sat_q;
        if (evt_clr_c) begin
            evt_cnt_d = evt ? EVT_CNT_W'(1) : '0;
            evt_sat_d = 1'b0;
        end else if (evt && (evt_cnt_q != EVT_MAX)) begin
            evt_cnt_d = evt_cnt_q + EVT_CNT_W'(1);
            if (evt_cnt_q == (EVT_MAX - EVT_CNT_W'(1))) begin
                evt_sat_d = 1'b1;
            end
        end
    end

    // Event counter registers.
    always_ff @(posedge pck0) begin
        if (!nrst) begin
            evt_cnt_q <= '0;
            evt_sat_q <= 1'b0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
            evt_sat_q <= evt_sat_d;
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
